// File: rtl/ysyx_22050710_mem_stage_pkg.sv
// Shared types and constants for the memory stage: bus widths, load
// operation encodings and the packed layouts of the stage's buses.
package ysyx_22050710_mem_stage_pkg;

    localparam int WORD_WD         = 64;
    localparam int PC_WD           = 64;
    localparam int INST_WD         = 32;
    localparam int GPR_WD          = 64;
    localparam int GPR_ADDR_WD     = 5;
    localparam int CSR_WD          = 64;
    localparam int CSR_ADDR_WD     = 12;
    localparam int ES_TO_MS_BUS_WD = 217;
    localparam int MS_TO_WS_BUS_WD = 147;
    localparam int BYPASS_BUS_WD   = 145;
    localparam int SRAM_DATA_WD    = 64;
    localparam int DEBUG_BUS_WD    = 225;

    // Load width/extension selector carried down from decode.
    typedef enum logic [2:0] {
        MEM_OP_LB   = 3'b000,
        MEM_OP_LH   = 3'b001,
        MEM_OP_LW   = 3'b010,
        MEM_OP_LD   = 3'b011,
        MEM_OP_LBU  = 3'b100,
        MEM_OP_LHU  = 3'b101,
        MEM_OP_LWU  = 3'b110,
        MEM_OP_RSVD = 3'b111
    } mem_op_e;

    // Execute -> memory bus, MSB first.
    typedef struct packed {
        logic [GPR_ADDR_WD-1:0] rd;
        logic [CSR_ADDR_WD-1:0] csr;
        logic                   gpr_wen;
        logic                   csr_wen;
        logic                   mem_ren;
        logic                   mem_wen;
        mem_op_e                mem_op;
        logic                   csr_inst_sel;
        logic [CSR_WD-1:0]      csrrdata;
        logic [WORD_WD-1:0]     alu_result;
        logic [CSR_WD-1:0]      csr_result;
    } es_to_ms_bus_t;

    // Memory -> write-back bus, MSB first.
    typedef struct packed {
        logic [GPR_ADDR_WD-1:0] rd;
        logic [CSR_ADDR_WD-1:0] csr;
        logic                   gpr_wen;
        logic                   csr_wen;
        logic [GPR_WD-1:0]      gpr_wdata;
        logic [CSR_WD-1:0]      csr_wdata;
    } ms_to_ws_bus_t;

    // Forwarding bus back to decode, MSB first.
    typedef struct packed {
        logic [GPR_ADDR_WD-1:0] rd;
        logic [GPR_WD-1:0]      gpr_wdata;
        logic [CSR_ADDR_WD-1:0] csr;
        logic [CSR_WD-1:0]      csr_wdata;
    } bypass_bus_t;

endpackage

// File: rtl/ysyx_22050710_mem_stage_if.sv
// Pipeline-side signals of the memory stage. The slave modport is the
// stage itself; the master modport is the surrounding pipeline.
interface ysyx_22050710_mem_stage_if;
    import ysyx_22050710_mem_stage_pkg::*;

    logic                       i_ws_allowin;
    logic                       o_ms_allowin;
    logic                       i_es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus;
    logic                       o_ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus;
    logic                       i_data_sram_data_ok;
    logic [SRAM_DATA_WD-1:0]    i_data_sram_rdata;
    logic                       o_ms_to_ds_load_sel;
    logic [BYPASS_BUS_WD-1:0]   o_ms_to_ds_bypass_bus;
    logic [DEBUG_BUS_WD-1:0]    i_debug_es_to_ms_bus;
    logic [DEBUG_BUS_WD-1:0]    o_debug_ms_to_ws_bus;

    modport slave (
        input  i_ws_allowin,
        output o_ms_allowin,
        input  i_es_to_ms_valid,
        input  i_es_to_ms_bus,
        output o_ms_to_ws_valid,
        output o_ms_to_ws_bus,
        input  i_data_sram_data_ok,
        input  i_data_sram_rdata,
        output o_ms_to_ds_load_sel,
        output o_ms_to_ds_bypass_bus,
        input  i_debug_es_to_ms_bus,
        output o_debug_ms_to_ws_bus
    );

    modport master (
        output i_ws_allowin,
        input  o_ms_allowin,
        output i_es_to_ms_valid,
        output i_es_to_ms_bus,
        input  o_ms_to_ws_valid,
        input  o_ms_to_ws_bus,
        output i_data_sram_data_ok,
        output i_data_sram_rdata,
        input  o_ms_to_ds_load_sel,
        input  o_ms_to_ds_bypass_bus,
        output i_debug_es_to_ms_bus,
        input  o_debug_ms_to_ws_bus
    );

endinterface

// File: rtl/ysyx_22050710_lsu_load.sv
// Load-side data alignment: moves the addressed bytes of an 8-byte aligned
// SRAM word down to bit 0 and sign/zero-extends them per the load type.
// Misaligned accesses do not trap; bytes past the end of the word read as 0.
module ysyx_22050710_lsu_load
    import ysyx_22050710_mem_stage_pkg::*;
(
    input  mem_op_e                 mem_op,
    input  logic [2:0]              addr_align,
    input  logic [SRAM_DATA_WD-1:0] rdata,
    output logic [WORD_WD-1:0]      rdata_ext
);

    logic [SRAM_DATA_WD-1:0] shifted;

    // Byte offset selects the lane; the logical shift zero-fills the top.
    assign shifted = rdata >> {addr_align, 3'b000};

    // Width selection and extension.
    always_comb begin
        // NOTE: a default is assigned first in every always_comb so no path leaves an output unassigned, which would infer a latch.
        rdata_ext = '0;
        case (mem_op)
            MEM_OP_LB:  rdata_ext = {{56{shifted[7]}},  shifted[7:0]};
            MEM_OP_LH:  rdata_ext = {{48{shifted[15]}}, shifted[15:0]};
            MEM_OP_LW:  rdata_ext = {{32{shifted[31]}}, shifted[31:0]};
            MEM_OP_LD:  rdata_ext = shifted;
            MEM_OP_LBU: rdata_ext = {56'b0, shifted[7:0]};
            MEM_OP_LHU: rdata_ext = {48'b0, shifted[15:0]};
            MEM_OP_LWU: rdata_ext = {32'b0, shifted[31:0]};
            default:    rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050710_mem_stage.sv
// Memory stage of the 5-stage pipeline. Holds one instruction from execute,
// waits for the data-SRAM response of a load (buffering it if write-back is
// stalled), aligns the load data and forwards the result to write-back and
// to decode's bypass network.
module ysyx_22050710_mem_stage
    import ysyx_22050710_mem_stage_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    ysyx_22050710_mem_stage_if.slave ms_if
);

    // Pipeline state.
    logic                    ms_valid_q,  ms_valid_d;
    es_to_ms_bus_t           bus_q,       bus_d;
    logic [DEBUG_BUS_WD-1:0] debug_q,     debug_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [SRAM_DATA_WD-1:0] buf_data_q,  buf_data_d;

    // Handshake and datapath nets.
    es_to_ms_bus_t           es_bus_in;
    logic                    ms_ready_go;
    logic                    ms_allowin;
    logic                    ms_to_ws_valid;
    logic                    ws_fire;
    logic                    load_wait;
    logic                    buf_capture;
    logic [SRAM_DATA_WD-1:0] load_src;
    logic [WORD_WD-1:0]      load_result;
    logic [GPR_WD-1:0]       gpr_wdata;
    logic                    bypass_en;
    ms_to_ws_bus_t           ws_bus;
    bypass_bus_t             bypass_bus;

    assign es_bus_in = es_to_ms_bus_t'(ms_if.i_es_to_ms_bus);

    // A load is done once its data has arrived now or was buffered earlier;
    // everything else (stores included) finishes in a single cycle here.
    assign ms_ready_go    = bus_q.mem_ren ? (ms_if.i_data_sram_data_ok || buf_valid_q) : 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ms_if.i_ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ws_fire        = ms_to_ws_valid && ms_if.i_ws_allowin;
    assign load_wait      = ms_valid_q && bus_q.mem_ren && !ms_ready_go;

    // Hold the response only when it cannot be handed to write-back this
    // cycle; a second response for the same load is not a pending one.
    assign buf_capture = ms_valid_q && bus_q.mem_ren && ms_if.i_data_sram_data_ok
                         && !ms_if.i_ws_allowin && !buf_valid_q;

    assign load_src = buf_valid_q ? buf_data_q : ms_if.i_data_sram_rdata;

    ysyx_22050710_lsu_load u_lsu_load (
        .mem_op     (bus_q.mem_op),
        .addr_align (bus_q.alu_result[2:0]),
        .rdata      (load_src),
        .rdata_ext  (load_result)
    );

    // Next-state for the pipeline register and the load data buffer.
    always_comb begin
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        debug_d     = debug_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;

        if (ms_allowin) begin
            ms_valid_d = ms_if.i_es_to_ms_valid;
        end
        if (ms_if.i_es_to_ms_valid && ms_allowin) begin
            bus_d   = es_bus_in;
            debug_d = ms_if.i_debug_es_to_ms_bus;
        end

        // Leaving and capturing are exclusive: one needs ws_allowin, the other its absence.
        if (ws_fire) begin
            buf_valid_d = 1'b0;
        end else if (buf_capture) begin
            buf_valid_d = 1'b1;
            buf_data_d  = ms_if.i_data_sram_rdata;
        end
    end

    // State registers with synchronous reset; a pending load and its buffer are dropped.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            debug_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            debug_q     <= debug_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end

    // CSR reads win over loads, loads over the ALU result.
    assign gpr_wdata = bus_q.csr_inst_sel ? bus_q.csrrdata
                     : bus_q.mem_ren      ? load_result
                     :                      bus_q.alu_result;

    // Stores write nothing back, and an unfinished load must not forward stale data.
    assign bypass_en = ms_valid_q && !bus_q.mem_wen && !(bus_q.mem_ren && !ms_ready_go);

    // Output bus assembly.
    always_comb begin
        ws_bus           = '0;
        ws_bus.rd        = bus_q.rd;
        ws_bus.csr       = bus_q.csr;
        ws_bus.gpr_wen   = bus_q.gpr_wen;
        ws_bus.csr_wen   = bus_q.csr_wen;
        ws_bus.gpr_wdata = gpr_wdata;
        ws_bus.csr_wdata = bus_q.csr_result;

        bypass_bus = '0;
        if (bypass_en) begin
            bypass_bus.rd        = bus_q.rd & {GPR_ADDR_WD{bus_q.gpr_wen}};
            bypass_bus.gpr_wdata = gpr_wdata & {GPR_WD{bus_q.gpr_wen}};
            bypass_bus.csr       = bus_q.csr & {CSR_ADDR_WD{bus_q.csr_wen}};
            bypass_bus.csr_wdata = bus_q.csr_result & {CSR_WD{bus_q.csr_wen}};
        end
    end

    assign ms_if.o_ms_allowin          = ms_allowin;
    assign ms_if.o_ms_to_ws_valid      = ms_to_ws_valid;
    assign ms_if.o_ms_to_ws_bus        = ws_bus;
    assign ms_if.o_ms_to_ds_load_sel   = load_wait;
    assign ms_if.o_ms_to_ds_bypass_bus = bypass_bus;
    assign ms_if.o_debug_ms_to_ws_bus  = debug_q;

endmodule
